// File: rtl/dc_fark_denetleyici.sv
// rtl/dc_fark_denetleyici.sv - JPEG luminance DC Huffman decode controller producing the signed DC difference
module dc_fark_denetleyici #(
    parameter int FARK_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              basla_i,
    input  logic              bit_i,
    input  logic              bit_gecerli_i,
    output logic              bit_hazir_o,
    output logic [3:0]        kategori_o,
    output logic [FARK_W-1:0] fark_o,
    output logic              cikis_gecerli_o,
    input  logic              cikis_hazir_i,
    output logic              mesgul_o,
    output logic              hata_o
);

    typedef enum logic [2:0] {BOSTA, KOD_OKU, EK_OKU, CIKIS, HATA} durum_t;

    durum_t      durum, sonraki;
    logic [7:0]  kod;
    logic [3:0]  uzunluk;
    logic [3:0]  ek_sayac;
    logic [9:0]  ek;
    logic [3:0]  kat;

    logic        aktarim;
    logic [8:0]  kod_yeni;
    logic [3:0]  uz_yeni;
    logic [8:0]  birler;
    logic        eslesme;
    logic        kod_hatasi;
    logic [3:0]  eslesen_kat;

    logic [10:0] v_tam;
    logic [10:0] maske;
    logic [10:0] v;
    logic [3:0]  kat_m1;
    logic        isaret;
    logic signed [11:0] fark_hes;

    assign aktarim  = bit_gecerli_i & bit_hazir_o;
    assign kod_yeni = {kod, bit_i};
    assign uz_yeni  = uzunluk + 4'd1;

    // Codes of length 4..9 are a run of ones terminated by a zero; category = length + 2.
    always_comb begin
        eslesme     = 1'b0;
        kod_hatasi  = 1'b0;
        eslesen_kat = 4'd0;
        birler      = (9'd1 << uz_yeni) - 9'd2;
        case (uz_yeni)
            4'd2: if (kod_yeni[1:0] == 2'b00) eslesme = 1'b1;
            4'd3: begin
                case (kod_yeni[2:0])
                    3'b010: begin eslesme = 1'b1; eslesen_kat = 4'd1; end
                    3'b011: begin eslesme = 1'b1; eslesen_kat = 4'd2; end
                    3'b100: begin eslesme = 1'b1; eslesen_kat = 4'd3; end
                    3'b101: begin eslesme = 1'b1; eslesen_kat = 4'd4; end
                    3'b110: begin eslesme = 1'b1; eslesen_kat = 4'd5; end
                    default: ;
                endcase
            end
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9: begin
                if (!kod_yeni[0] && ((kod_yeni & birler) == birler)) begin
                    eslesme     = 1'b1;
                    eslesen_kat = uz_yeni + 4'd2;
                end else if (uz_yeni == 4'd9) begin
                    kod_hatasi = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Difference from the k additional bits including the one arriving this cycle.
    always_comb begin
        v_tam    = {ek, bit_i};
        maske    = (11'd1 << kat) - 11'd1;
        v        = v_tam & maske;
        kat_m1   = kat - 4'd1;
        isaret   = v_tam[kat_m1];
        fark_hes = isaret ? {1'b0, v} : ({1'b0, v} - {1'b0, maske});
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) durum <= BOSTA;
        else        durum <= sonraki;
    end

    always_comb begin
        sonraki = durum;
        case (durum)
            BOSTA:   if (basla_i) sonraki = KOD_OKU;
            KOD_OKU: begin
                if (aktarim) begin
                    if (eslesme)         sonraki = (eslesen_kat == 4'd0) ? CIKIS : EK_OKU;
                    else if (kod_hatasi) sonraki = HATA;
                end
            end
            EK_OKU:  if (aktarim && ek_sayac == 4'd1) sonraki = CIKIS;
            CIKIS:   if (cikis_hazir_i) sonraki = BOSTA;
            HATA:    if (basla_i) sonraki = KOD_OKU;
            default: sonraki = BOSTA;
        endcase
    end

    always_comb begin
        bit_hazir_o     = (durum == KOD_OKU) || (durum == EK_OKU);
        cikis_gecerli_o = (durum == CIKIS);
        mesgul_o        = (durum != BOSTA);
        hata_o          = (durum == HATA);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            kod        <= '0;
            uzunluk    <= '0;
            ek_sayac   <= '0;
            ek         <= '0;
            kat        <= '0;
            kategori_o <= '0;
            fark_o     <= '0;
        end else begin
            case (durum)
                BOSTA, HATA: begin
                    if (basla_i) begin
                        kod      <= '0;
                        uzunluk  <= '0;
                        ek_sayac <= '0;
                        ek       <= '0;
                        kat      <= '0;
                    end
                end
                KOD_OKU: begin
                    if (aktarim) begin
                        kod     <= kod_yeni[7:0];
                        uzunluk <= uz_yeni;
                        if (eslesme) begin
                            if (eslesen_kat == 4'd0) begin
                                kategori_o <= 4'd0;
                                fark_o     <= '0;
                            end else begin
                                ek_sayac <= eslesen_kat;
                                ek       <= '0;
                                kat      <= eslesen_kat;
                            end
                        end
                    end
                end
                EK_OKU: begin
                    if (aktarim) begin
                        ek       <= v_tam[9:0];
                        ek_sayac <= ek_sayac - 4'd1;
                        if (ek_sayac == 4'd1) begin
                            kategori_o <= kat;
                            fark_o     <= FARK_W'(fark_hes);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dc_fark_denetleyici.sv
// tb/tb_dc_fark_denetleyici.sv - self-checking bench for dc_fark_denetleyici
module tb_dc_fark_denetleyici;

    localparam int FARK_W = 12;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              basla_i;
    logic              bit_i;
    logic              bit_gecerli_i;
    logic              bit_hazir_o;
    logic [3:0]        kategori_o;
    logic [FARK_W-1:0] fark_o;
    logic              cikis_gecerli_o;
    logic              cikis_hazir_i;
    logic              mesgul_o;
    logic              hata_o;

    dc_fark_denetleyici #(.FARK_W(FARK_W)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .basla_i        (basla_i),
        .bit_i          (bit_i),
        .bit_gecerli_i  (bit_gecerli_i),
        .bit_hazir_o    (bit_hazir_o),
        .kategori_o     (kategori_o),
        .fark_o         (fark_o),
        .cikis_gecerli_o(cikis_gecerli_o),
        .cikis_hazir_i  (cikis_hazir_i),
        .mesgul_o       (mesgul_o),
        .hata_o         (hata_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [19:0] akis;
        int          n;
        int          kat;
        int          fark;
        bit          hata;
        bit          bubble;
        int          hold;
    } vek_t;

    vek_t tablo[8];
    int   kod_deger[12];
    int   kod_uz[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int beklenen_fark(input int k, input int v);
        if (k == 0) return 0;
        if (((v >> (k - 1)) & 1) == 1) return v;
        return v - ((1 << k) - 1);
    endfunction

    task automatic send(input logic [19:0] akis, input int n, input bit bubble, output int cyc);
        int  bi;
        bit  g;
        logic h;
        bi  = n - 1;
        cyc = 0;
        while (bi >= 0 && cyc < 500) begin
            g = bubble ? bit'($urandom_range(0, 1)) : 1'b1;
            bit_gecerli_i = g;
            bit_i = akis[bi];
            h = bit_hazir_o;
            @(negedge clk);
            if (g && h) bi--;
            cyc++;
        end
        if (bi >= 0) chk("send_timeout", bi, -1);
    endtask

    task automatic run(input string name, input logic [19:0] akis, input int n, input int kat,
                       input int fark, input bit hata, input bit bubble, input int hold);
        int cyc;
        @(negedge clk) basla_i = 1'b1;
        @(negedge clk) basla_i = 1'b0;
        chk({name, "_hazir_after_basla"}, int'(bit_hazir_o), 1);
        chk({name, "_hata_cleared"}, int'(hata_o), 0);
        send(akis, n, bubble, cyc);
        bit_gecerli_i = 1'b0;
        if (!bubble) chk({name, "_cycles"}, cyc, n);
        if (hata) begin
            chk({name, "_hata"}, int'(hata_o), 1);
            chk({name, "_hazir_in_hata"}, int'(bit_hazir_o), 0);
            chk({name, "_no_valid"}, int'(cikis_gecerli_o), 0);
            repeat (3) @(negedge clk);
            chk({name, "_hata_sticky"}, int'(hata_o), 1);
            chk({name, "_no_valid_later"}, int'(cikis_gecerli_o), 0);
        end else begin
            chk({name, "_valid"}, int'(cikis_gecerli_o), 1);
            chk({name, "_kat"}, int'(kategori_o), kat);
            chk({name, "_fark"}, int'($signed(fark_o)), fark);
            chk({name, "_hazir_in_cikis"}, int'(bit_hazir_o), 0);
            for (int i = 0; i < hold; i++) begin
                basla_i = (i % 2 == 0);
                @(negedge clk);
                chk({name, "_hold_valid"}, int'(cikis_gecerli_o), 1);
                chk({name, "_hold_kat"}, int'(kategori_o), kat);
                chk({name, "_hold_fark"}, int'($signed(fark_o)), fark);
                chk({name, "_hold_hazir"}, int'(bit_hazir_o), 0);
            end
            basla_i = 1'b0;
            cikis_hazir_i = 1'b1;
            @(negedge clk);
            cikis_hazir_i = 1'b0;
            chk({name, "_valid_dropped"}, int'(cikis_gecerli_o), 0);
            chk({name, "_idle"}, int'(mesgul_o), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, k, v, f;
        logic [19:0] akis;

        kod_deger = '{0, 2, 3, 4, 5, 6, 14, 30, 62, 126, 254, 510};
        kod_uz    = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9};

        tablo[0] = '{20'b01110,                 5,  2,     2, 1'b0, 1'b0, 0};
        tablo[1] = '{20'b00,                    2,  0,     0, 1'b0, 1'b0, 0};
        tablo[2] = '{20'b1010010,               7,  4,   -13, 1'b0, 1'b0, 1};
        tablo[3] = '{20'b11111111011111111111, 20, 11,  2047, 1'b0, 1'b0, 0};
        tablo[4] = '{20'b11111111000000000000, 20, 11, -2047, 1'b0, 1'b0, 0};
        tablo[5] = '{20'b111111111,             9,  0,     0, 1'b1, 1'b0, 0};
        tablo[6] = '{20'b0101,                  4,  1,     1, 1'b0, 1'b0, 0};
        tablo[7] = '{20'b100011,                6,  3,    -4, 1'b0, 1'b1, 5};

        rst_i = 1'b0; basla_i = 1'b0; bit_i = 1'b0; bit_gecerli_i = 1'b0; cikis_hazir_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_hazir", int'(bit_hazir_o), 0);
        chk("reset_valid", int'(cikis_gecerli_o), 0);
        chk("reset_mesgul", int'(mesgul_o), 0);
        chk("reset_hata", int'(hata_o), 0);
        chk("reset_kat", int'(kategori_o), 0);
        chk("reset_fark", int'($signed(fark_o)), 0);
        rst_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run($sformatf("vec%0d", i), tablo[i].akis, tablo[i].n, tablo[i].kat,
                tablo[i].fark, tablo[i].hata, tablo[i].bubble, tablo[i].hold);

        for (int r = 0; r < 40; r++) begin
            k = $urandom_range(0, 11);
            v = (k == 0) ? 0 : int'($urandom_range(0, (1 << k) - 1));
            f = beklenen_fark(k, v);
            akis = 20'((kod_deger[k] << k) | v);
            run($sformatf("rnd%0d_k%0d", r, k), akis, kod_uz[k] + k, k, f, 1'b0,
                bit'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        // Reset in the middle of the additional bits of a category-4 code.
        run("pre_reset", 20'b01110, 5, 2, 2, 1'b0, 1'b0, 0);
        @(negedge clk) basla_i = 1'b1;
        @(negedge clk) basla_i = 1'b0;
        send(20'b10100, 5, 1'b0, cyc);
        bit_gecerli_i = 1'b0;
        chk("mid_ek_hazir", int'(bit_hazir_o), 1);
        chk("mid_ek_mesgul", int'(mesgul_o), 1);
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_hazir", int'(bit_hazir_o), 0);
        chk("async_rst_mesgul", int'(mesgul_o), 0);
        chk("async_rst_valid", int'(cikis_gecerli_o), 0);
        chk("async_rst_kat", int'(kategori_o), 0);
        chk("async_rst_fark", int'($signed(fark_o)), 0);
        @(negedge clk);
        chk("rst_hold_valid", int'(cikis_gecerli_o), 0);
        rst_i = 1'b1;
        @(negedge clk);
        run("post_reset", 20'b01110, 5, 2, 2, 1'b0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dc_fark_denetleyici.md
# dc_fark_denetleyici

Sequencing controller for JPEG luminance DC decoding. Pulls a bit-serial entropy stream one bit per handshake, resolves the DC Huffman code (categories 0–11), then fetches that many additional bits and produces the signed DC difference. Sits between the bitstream buffer and the DC predictor/accumulator. Replaces ad-hoc, fixed-length DC code capture with a length-agnostic, back-pressured decode.

## Interface
- `FARK_W`, default 12: width of the signed difference output. Must be ≥ 12.
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `basla_i` input 1: start one DC decode. Sampled only in BOSTA or HATA.
- `bit_i` input 1: next stream bit, MSB-first order.
- `bit_gecerli_i` input 1: `bit_i` is valid.
- `bit_hazir_o` output 1: controller accepts a bit this cycle. Transfer occurs when `bit_gecerli_i & bit_hazir_o`.
- `kategori_o` output 4: decoded category 0–11.
- `fark_o` output `FARK_W`: signed DC difference, two's complement.
- `cikis_gecerli_o` output 1: `kategori_o`/`fark_o` valid.
- `cikis_hazir_i` input 1: consumer accepts the result.
- `mesgul_o` output 1: state is not BOSTA.
- `hata_o` output 1: invalid code detected. Sticky until the next `basla_i`.

## Operation
- Code table (code bits → category), fixed:
  - 00→0, 010→1, 011→2, 100→3, 101→4, 110→5
  - 1110→6, 11110→7, 111110→8, 1111110→9, 11111110→10, 111111110→11
  - 111111111 → error.
- FSM states: BOSTA, KOD_OKU, EK_OKU, CIKIS, HATA.
- BOSTA:
  - `bit_hazir_o`=0.
  - On `basla_i`: clear code shift register and length counter (4 bits), go to KOD_OKU.
- KOD_OKU:
  - `bit_hazir_o`=1.
  - Each transfer shifts the bit into the code register LSB and increments the length.
  - The match is evaluated on the post-shift {code, length} in the same cycle as the transfer.
  - Category 0 match: `fark`←0, go to CIKIS.
  - Category k>0 match: `ek_sayac`←k, clear the additional-bit register, go to EK_OKU.
  - Length 9 with no match: go to HATA.
  - Without a valid transfer, the state holds.
- EK_OKU:
  - `bit_hazir_o`=1.
  - Each transfer shifts into the additional-bit register (11 bits) and decrements `ek_sayac`.
  - When the final bit transfers (`ek_sayac`==1), compute `fark` on that edge and go to CIKIS.
- Difference rule, with V = additional bits and k = category:
  - If V[k-1]=1: `fark` = +V.
  - Otherwise: `fark` = V − (2^k − 1).
  - Sign-extend to `FARK_W`. Range −2047…+2047.
- CIKIS:
  - `cikis_gecerli_o`=1 and `bit_hazir_o`=0.
  - Outputs are held stable until `cikis_hazir_i`=1, then go to BOSTA.
- HATA:
  - `hata_o`=1 and `bit_hazir_o`=0.
  - `basla_i` clears `hata_o`, clears the registers, and goes directly to KOD_OKU.
- `basla_i` is ignored in KOD_OKU, EK_OKU and CIKIS.
- `kategori_o`/`fark_o` are registered and change only on entry to CIKIS.

## Timing
- Reset (`rst_i`=0, asynchronous, at any time including mid-decode):
  - State → BOSTA.
  - `bit_hazir_o`, `cikis_gecerli_o`, `mesgul_o`, `hata_o` = 0.
  - `kategori_o` = 0, `fark_o` = 0.
  - All counters and registers cleared.
  - A partially decoded code is discarded; no output is produced for it.
- `basla_i` at edge E → `bit_hazir_o`=1 in the cycle after E.
- Latency with no bubbles: the decode takes L+k accepting cycles, where L = code length.
  - `cikis_gecerli_o` rises in the cycle after the edge at which the last bit transfers.
  - Category 0: two bits, then valid.
- Bubbles (`bit_gecerli_i`=0) stall the FSM without changing any state.
- The result handshake completes on an edge where `cikis_gecerli_o & cikis_hazir_i`.
  - The next cycle is BOSTA.
  - Back-to-back decodes need `basla_i` in that BOSTA cycle. Minimum gap between results: 2 cycles + bits.
- `bit_hazir_o` is a pure function of the state; it does not combinationally depend on `bit_gecerli_i`.

## Test plan
- Cat 2, positive: reset, `basla_i`, stream 011,10 with no bubbles.
  - Expect `kategori_o`=2, `fark_o`=+2.
  - `cikis_gecerli_o` is high in the cycle after the 5th transfer.
- Cat 0 and cat 4, negative:
  - Stream 00 → `kategori_o`=0, `fark_o`=0 after 2 bits.
  - Then `basla_i`, stream 101,0010 → `kategori_o`=4, `fark_o`=−13.
- Cat 11 extremes:
  - Stream 111111110 + eleven 1s → `kategori_o`=11, `fark_o`=+2047.
  - Stream 111111110 + eleven 0s → `fark_o`=−2047.
- Error path: stream nine 1s.
  - `hata_o`=1, `bit_hazir_o`=0, no `cikis_gecerli_o`.
  - `basla_i` clears `hata_o`; then stream 010,1 → `kategori_o`=1, `fark_o`=+1.
- Backpressure and bubbles:
  - Random `bit_gecerli_i` gaps during stream 100,011 → result `fark_o`=−4.
  - Hold `cikis_hazir_i`=0 for 5 cycles: outputs stable, `bit_hazir_o`=0, `basla_i` pulses ignored.
- Reset mid-EK_OKU: assert `rst_i`=0 after 2 of 4 additional bits.
  - All outputs 0 immediately.
  - After release, a fresh decode of 011,10 gives `fark_o`=+2.
